// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch-stage PC register and next-PC selection, plus a circular
// return-address stack that checks return targets against the GPR value and
// keeps saturating hit/miss counters. The stack is advisory and never steers nPC.
module pc_unit_ras #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int          RAS_DEPTH   = 4,
    parameter int          CNT_W       = 16
) (
    input  logic             PCU_i_Clk,
    input  logic             PCU_i_Reset_n,
    input  logic             PCU_i_Stall,
    input  logic             PCU_i_Exception,
    input  logic [2:0]       PCU_i_Mode,
    input  logic             PCU_i_Condition,
    input  logic [25:0]      PCU_i_Immediate,
    input  logic [31:0]      PCU_i_RegAddr,
    input  logic [31:0]      PCU_i_EPCAddr,
    input  logic             PCU_i_Link,
    output logic [31:0]      PCU_o_PC,
    output logic [31:0]      PCU_o_nPC,
    output logic             PCU_o_Misalign,
    output logic             PCU_o_RasHit,
    output logic             PCU_o_RasMiss,
    output logic [CNT_W-1:0] PCU_o_HitCnt,
    output logic [CNT_W-1:0] PCU_o_MissCnt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [2:0] {
        MODE_NORMAL = 3'd0,
        MODE_BRANCH = 3'd1,
        MODE_JUMP   = 3'd2,
        MODE_JREG   = 3'd3,
        MODE_ERET   = 3'd4,
        MODE_RET    = 3'd5
    } mode_e;

    logic [31:0]      pc_q;
    logic [31:0]      npc;
    logic [31:0]      branch_off;
    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_pop, ptr_d, top_idx;
    logic [OCC_W-1:0] occ_q, occ_pop, occ_d;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic             update_en, is_ret, stack_nonempty, top_match;
    logic             ras_hit, ras_miss, do_pop, do_push;

    // Word offset sign-extended and scaled to bytes.
    assign branch_off = {{14{PCU_i_Immediate[15]}}, PCU_i_Immediate[15:0], 2'b00};

    // Next-PC selection: exception first, then the requested mode.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        npc = pc_q + 32'd4;
        if (PCU_i_Exception) begin
            npc = EXC_VECTOR;
        end else begin
            case (PCU_i_Mode)
                MODE_BRANCH: if (PCU_i_Condition) npc = pc_q + branch_off;
                MODE_JUMP:   npc = {pc_q[31:28], PCU_i_Immediate, 2'b00};
                MODE_JREG,
                MODE_RET:    npc = PCU_i_RegAddr;
                MODE_ERET:   npc = PCU_i_EPCAddr & ~32'h3;
                default:     ;
            endcase
        end
    end

    // Stack control: only a non-stalled, non-exception cycle may touch the stack.
    assign update_en      = !PCU_i_Stall && !PCU_i_Exception;
    assign is_ret         = update_en && (PCU_i_Mode == MODE_RET);
    assign stack_nonempty = (occ_q != '0);
    assign top_idx        = ptr_q - PTR_W'(1);
    assign top_match      = (ras_mem[top_idx] == PCU_i_RegAddr);
    assign ras_hit        = is_ret && stack_nonempty && top_match;
    assign ras_miss       = is_ret && !(stack_nonempty && top_match);
    assign do_pop         = is_ret && stack_nonempty;
    assign do_push        = update_en && PCU_i_Link;

    // Pop is applied before push so RET+Link replaces the top in place.
    always_comb begin
        ptr_pop = do_pop ? ptr_q - PTR_W'(1) : ptr_q;
        occ_pop = do_pop ? occ_q - OCC_W'(1) : occ_q;
        ptr_d   = do_push ? ptr_pop + PTR_W'(1) : ptr_pop;
        occ_d   = (do_push && occ_pop != OCC_W'(RAS_DEPTH)) ? occ_pop + OCC_W'(1) : occ_pop;
    end

    // Stack storage write; a push onto a full stack overwrites the oldest entry.
    // NOTE: entries carry no reset; the occupancy count already makes stale data unreadable.
    always_ff @(posedge PCU_i_Clk) begin
        if (do_push) ras_mem[ptr_pop] <= pc_q + LINK_OFFSET;
    end

    // PC, stack pointers and saturating counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCU_i_Clk or negedge PCU_i_Reset_n) begin
        if (!PCU_i_Reset_n) begin
            pc_q       <= RESET_PC;
            ptr_q      <= '0;
            occ_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (PCU_i_Exception || !PCU_i_Stall) pc_q <= npc;
            ptr_q <= ptr_d;
            occ_q <= occ_d;
            if (ras_hit && hit_cnt_q != {CNT_W{1'b1}})   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
            if (ras_miss && miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign PCU_o_PC       = pc_q;
    assign PCU_o_nPC      = npc;
    assign PCU_o_Misalign = |pc_q[1:0];
    assign PCU_o_RasHit   = ras_hit;
    assign PCU_o_RasMiss  = ras_miss;
    assign PCU_o_HitCnt   = hit_cnt_q;
    assign PCU_o_MissCnt  = miss_cnt_q;

endmodule
